board_scan_reader: RTL
======================

# board_scan_reader

Reads the 32x24 tile board RAM one tile at a time, from address 0 to 767. Each tile goes out on a valid/ready stream, tagged with its (x, y) position, for the renderer and game-logic consumers. While it scans, it counts pellet and power-pellet tiles, so the game FSM can detect a cleared board. It sits on the read port of the board RAM, the same RAM that the board-reset path fills from ROM.

## Interface
Parameters:
- ADDR_W, 10, board RAM address width
- DATA_W, 4, tile code width
- LAST_ADDR, 767, final tile address (10'b1011111111)
- PELLET_CODE, 4'h1, tile code counted as a pellet
- POWER_CODE, 4'h2, tile code counted as a power pellet

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low; resets the block when sampled low at a rising edge
- start  in  1  single-cycle request to begin a full board scan
- read_addr  out  ADDR_W  board RAM read address
- read_data  in  DATA_W  board RAM output; valid on the second rising edge after read_addr changes
- tile_valid  out  1  tile_data, tile_x, tile_y and tile_last are valid
- tile_ready  in  1  consumer accepts the current tile
- tile_data  out  DATA_W  tile code
- tile_x  out  5  column, equal to the tile address bits [4:0]
- tile_y  out  5  row, equal to the tile address bits [9:5]
- tile_last  out  1  current tile is at LAST_ADDR
- busy  out  1  a scan is in progress (any state other than IDLE)
- done  out  1  one-cycle pulse after the last tile is accepted
- pellet_count  out  ADDR_W  pellet plus power-pellet count from the last completed scan
- board_clear  out  1  at least one scan has completed and pellet_count == 0

## Operation
States:
- IDLE: wait for start.
- FETCH: read_addr is stable; the RAM samples the address.
- WAIT: the RAM output settles; read_data is captured into tile_data on the edge that leaves WAIT.
- PRESENT: tile_valid = 1; hold until tile_ready.
- DONE: publish results for one cycle.

Transitions:
- IDLE to FETCH on start. read_addr <= 0 and the running count is cleared on that edge.
- FETCH to WAIT, and WAIT to PRESENT, unconditionally.
- PRESENT, when tile_valid and tile_ready are both high:
  - If read_addr != LAST_ADDR: go to FETCH and set read_addr <= read_addr + 1.
  - If read_addr == LAST_ADDR: go to DONE.
- DONE to IDLE unconditionally.

Stream rules:
- In PRESENT, tile_data, tile_x, tile_y and tile_last stay constant until the handshake.
- tile_valid never drops without a handshake, except on reset.
- tile_ready is a don't-care outside PRESENT.

Counting:
- On each handshake where tile_data equals PELLET_CODE or POWER_CODE, the running count increments by 1.
- The maximum count is 768, which fits in 10 bits; no saturation logic is needed.
- In DONE, pellet_count <= final running count (including the last tile), done = 1, and board_clear is updated.
- pellet_count and board_clear hold between scans.

Boundary cases:
- start while busy is ignored; no restart and no queuing.
- read_addr never goes past LAST_ADDR and never wraps during a scan.
- A handshake on the last tile and a start in the same cycle: start is ignored, because busy is still high.

Reset values (when reset is sampled low, in any state, including mid-scan): state IDLE, read_addr 0, tile_valid 0, tile_data 0, tile_last 0, done 0, pellet_count 0, board_clear 0, running count 0. A scan interrupted by reset produces no done and leaves pellet_count at 0.

## Timing
- start sampled at edge k: FETCH in cycle k+1, WAIT in cycle k+2, tile_valid high in cycle k+3.
- Each tile costs 3 cycles plus any consumer stall: a handshake at edge j gives the next tile_valid in cycle j+3.
- With tile_ready tied high, a full scan takes 768 x 3 = 2304 cycles. done is high in the cycle after the final handshake, and busy drops one cycle later.
- tile_x and tile_y are combinational from read_addr and are valid whenever tile_valid is high.
- read_addr changes only on the IDLE-to-FETCH edge and on handshake edges.

## Test plan
- All-zero RAM, tile_ready = 1, pulse start:
  - 768 tiles, all tile_data 0, with (x, y) running (0,0), (1,0), ... (31,23).
  - tile_last only on (31,23).
  - done exactly one cycle after the final handshake.
  - pellet_count 0, board_clear 1.
- RAM with PELLET_CODE at 100 addresses and POWER_CODE at 4 addresses: pellet_count 104, board_clear 0.
- Random tile_ready stalls, including ready held low for 10 cycles at address 0 and at 767:
  - tile_data and tile_x/tile_y stable while stalled.
  - No tiles skipped or duplicated.
  - Count matches a reference model.
- start pulsed again mid-scan at address 300:
  - Ignored; the scan completes normally.
  - Exactly one done pulse.
  - A later start rescans from address 0.
- reset driven low at address 500 while tile_valid is high:
  - The next cycle shows tile_valid 0, busy 0, pellet_count 0, board_clear 0.
  - No done pulse.
- Latency check: start at edge k gives tile_valid in cycle k+3 and read_addr 0 throughout.

Source files
------------

// File: rtl/board_scan_reader.sv
// Streams every tile of the 32x24 board RAM out on a valid/ready port, tagged with (x, y),
// while counting pellet and power-pellet tiles for cleared-board detection.
module board_scan_reader #(
    parameter int unsigned       ADDR_W      = 10,
    parameter int unsigned       DATA_W      = 4,
    parameter logic [ADDR_W-1:0] LAST_ADDR   = 10'd767,
    parameter logic [DATA_W-1:0] PELLET_CODE = 4'h1,
    parameter logic [DATA_W-1:0] POWER_CODE  = 4'h2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [DATA_W-1:0] tile_data,
    output logic [4:0]        tile_x,
    output logic [4:0]        tile_y,
    output logic              tile_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pellet_count,
    output logic              board_clear
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StPresent,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] pellet_count_q;
    logic [DATA_W-1:0] tile_data_q;
    logic              tile_valid_q;
    logic              tile_last_q;
    logic              done_q;
    logic              board_clear_q;

    logic              handshake;
    logic              is_pellet;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        handshake = tile_valid_q && tile_ready;
        is_pellet = (tile_data_q == PELLET_CODE) || (tile_data_q == POWER_CODE);
        cnt_d     = cnt_q;
        if (handshake && is_pellet) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            cnt_q          <= '0;
            pellet_count_q <= '0;
            tile_data_q    <= '0;
            tile_valid_q   <= 1'b0;
            tile_last_q    <= 1'b0;
            done_q         <= 1'b0;
            board_clear_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                        addr_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                StFetch: begin
                    state_q <= StWait;
                end
                StWait: begin
                    // RAM output is valid on this edge: two edges after the address moved.
                    state_q      <= StPresent;
                    tile_data_q  <= read_data;
                    tile_last_q  <= (addr_q == LAST_ADDR);
                    tile_valid_q <= 1'b1;
                end
                StPresent: begin
                    if (handshake) begin
                        tile_valid_q <= 1'b0;
                        tile_last_q  <= 1'b0;
                        cnt_q        <= cnt_d;
                        if (addr_q == LAST_ADDR) begin
                            // Results are published together with the done pulse.
                            state_q        <= StDone;
                            done_q         <= 1'b1;
                            pellet_count_q <= cnt_d;
                            board_clear_q  <= (cnt_d == '0);
                        end else begin
                            state_q <= StFetch;
                            addr_q  <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign read_addr    = addr_q;
    assign tile_valid   = tile_valid_q;
    assign tile_data    = tile_data_q;
    assign tile_x       = addr_q[4:0];
    assign tile_y       = addr_q[9:5];
    assign tile_last    = tile_last_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign pellet_count = pellet_count_q;
    assign board_clear  = board_clear_q;

endmodule
